// File: rtl/irq_sequencer.sv
// irq_sequencer: reset/interrupt entry sequencer that pushes return state and fetches the handler vector (define IRQ_COP_EN to decode COP)
module irq_sequencer #(
    parameter int          ADDR_W  = 16,
    parameter logic [15:0] VEC_NMI = 16'hFFFA,
    parameter logic [15:0] VEC_RST = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ = 16'hFFFE,
    parameter logic [15:0] VEC_BRK = 16'hFFFE,
    parameter logic [15:0] VEC_COP = 16'hFFF4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              locked,
    output logic [ADDR_W-1:0] address,
    input  logic [7:0]        i_data,
    output logic [7:0]        o_data,
    output logic              we,
    input  logic              nmi_n,
    input  logic              irq_n,
    input  logic              sw_req,
    input  logic              sw_cop,
    input  logic              boundary,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [7:0]        p_in,
    input  logic [7:0]        s_in,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc_out,
    output logic [7:0]        p_out,
    output logic [7:0]        s_out
);
    typedef enum logic [2:0] {IDLE, PUSH_PBR, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, FIN} state_t;
    localparam bit WIDE = ADDR_W == 24;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       pc_q, vec_q, pcout_q, sw_vec;
    logic [7:0]        p_q, s_q, odata_q, pout_q, sout_q, push_byte;
    logic              we_q, busy_q, done_q, brk_q, dummy_q, nmi_prev_q, nmi_pend_q, nmi_pend_d;
    logic              nmi_edge, nmi_hit, irq_hit, accept, take_nmi;

`ifdef IRQ_COP_EN
    assign sw_vec = sw_cop ? VEC_COP : VEC_BRK;
`else
    logic unused_sw_cop;
    assign unused_sw_cop = sw_cop;
    assign sw_vec = VEC_BRK;
`endif

    // An edge seen on the acceptance cycle itself counts, so NMI beats a simultaneous IRQ
    assign nmi_edge   = nmi_prev_q & ~nmi_n;
    assign nmi_hit    = nmi_pend_q | nmi_edge;
    assign irq_hit    = ~irq_n & ~p_in[2];
    assign accept     = state_q == IDLE && boundary && (sw_req || nmi_hit || irq_hit);
    assign take_nmi   = accept & ~sw_req & nmi_hit;
    assign nmi_pend_d = nmi_hit & ~(locked & take_nmi);
    assign push_byte  = state_q == PUSH_PBR ? pc_q[15:8] :
                        state_q == PUSH_PCH ? pc_q[7:0]  : {p_q[7:6], 1'b1, brk_q, p_q[3:0]};

    assign address = state_q == IDLE ? pc_in : addr_q;
    assign o_data  = odata_q;
    assign we      = we_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pc_out  = ADDR_W'(pcout_q);
    assign p_out   = pout_q;
    assign s_out   = sout_q;

    // Sequencer FSM; each state's bus cycle is registered on the edge that enters it
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= PUSH_PCH;
            addr_q     <= ADDR_W'(16'h0100);
            s_q        <= 8'hFF;
            we_q       <= 1'b0;
            odata_q    <= 8'h00;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            dummy_q    <= 1'b1;
            brk_q      <= 1'b0;
            vec_q      <= VEC_RST;
            pc_q       <= 16'h0000;
            p_q        <= 8'h00;
            nmi_prev_q <= nmi_n;
            nmi_pend_q <= 1'b0;
        end else begin
            nmi_prev_q <= nmi_n;
            nmi_pend_q <= nmi_pend_d;
            if (locked) begin
                case (state_q)
                    IDLE: if (accept) begin
                        pc_q    <= pc_in[15:0];
                        p_q     <= p_in;
                        brk_q   <= sw_req;
                        dummy_q <= 1'b0;
                        vec_q   <= sw_req ? sw_vec : nmi_hit ? VEC_NMI : VEC_IRQ;
                        busy_q  <= 1'b1;
                        addr_q  <= ADDR_W'({8'h01, s_in});
                        s_q     <= s_in - 8'd1;
                        we_q    <= 1'b1;
                        odata_q <= WIDE ? 8'(24'(pc_in) >> 16) : pc_in[15:8];
                        state_q <= WIDE ? PUSH_PBR : PUSH_PCH;
                    end
                    PUSH_PBR, PUSH_PCH, PUSH_PCL: begin
                        addr_q  <= ADDR_W'({8'h01, s_q});
                        s_q     <= s_q - 8'd1;
                        we_q    <= ~dummy_q;
                        odata_q <= push_byte;
                        state_q <= state_t'(state_q + 3'd1);
                    end
                    PUSH_P: begin
                        addr_q  <= ADDR_W'(vec_q);
                        we_q    <= 1'b0;
                        state_q <= VEC_LO;
                    end
                    VEC_LO: begin
                        pcout_q[7:0] <= i_data;
                        addr_q       <= ADDR_W'(vec_q + 16'd1);
                        state_q      <= VEC_HI;
                    end
                    VEC_HI: begin
                        pcout_q[15:8] <= i_data;
                        pout_q        <= {p_q[7:4], 1'b0, 1'b1, p_q[1:0]};
                        sout_q        <= s_q;
                        done_q        <= 1'b1;
                        state_q       <= FIN;
                    end
                    FIN: begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
